// File: rtl/fpu_mul_pipe_if.sv
// rtl/fpu_mul_pipe_if.sv - operand/result handshake bundle for the pipelined FP multiplier
interface fpu_mul_pipe_if #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23,
  parameter int SIZE_TAG = 4
) ();
  localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN;

  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_32_a;
  logic [SIZE_DATA-1:0] i_32_b;
  logic [SIZE_TAG-1:0]  i_tag;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_32_mul;
  logic [SIZE_TAG-1:0]  o_tag;
  logic [3:0]           o_flags;

  modport slave (
    input  i_valid, i_32_a, i_32_b, i_tag, i_ready,
    output o_ready, o_valid, o_32_mul, o_tag, o_flags
  );

  modport master (
    output i_valid, i_32_a, i_32_b, i_tag, i_ready,
    input  o_ready, o_valid, o_32_mul, o_tag, o_flags
  );
endinterface

// File: rtl/fpu_mul_pipe.sv
// rtl/fpu_mul_pipe.sv - three-stage IEEE-754 multiplier (unpack, multiply, normalise/round), FTZ
module fpu_mul_pipe #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23,
  parameter int SIZE_TAG = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  fpu_mul_pipe_if.slave bus
);
  localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN;
  localparam int SIZE_SE   = SIZE_EXP + 2;
  localparam int SIZE_M1   = SIZE_MAN + 1;
  localparam int SIZE_P    = 2 * SIZE_M1;

  localparam logic [SIZE_EXP-1:0]        EXP_ONES = '1;
  localparam logic signed [SIZE_SE-1:0]  BIAS     = SIZE_SE'((1 << (SIZE_EXP - 1)) - 1);
  localparam logic signed [SIZE_SE-1:0]  SE_ONES  = {2'b00, EXP_ONES};
  localparam logic signed [SIZE_SE-1:0]  SE_ZERO  = '0;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_QNAN} kind_t;

  // Unpack
  logic                sa, sb;
  logic [SIZE_EXP-1:0] ea, eb;
  logic [SIZE_MAN-1:0] fa, fb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  kind_t               kind_in;
  logic                inv_in;
  logic signed [SIZE_SE-1:0] exp_in;

  assign {sa, ea, fa} = bus.i_32_a;
  assign {sb, eb, fb} = bus.i_32_b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_snan = a_nan && !fa[SIZE_MAN-1];
  assign b_snan = b_nan && !fb[SIZE_MAN-1];
  assign exp_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  always_comb begin
    kind_in = K_NORM;
    inv_in  = 1'b0;
    if (a_nan || b_nan) begin
      kind_in = K_QNAN;
      inv_in  = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      kind_in = K_QNAN;
      inv_in  = 1'b1;
    end else if (a_inf || b_inf) begin
      kind_in = K_INF;
    end else if (a_zero || b_zero) begin
      kind_in = K_ZERO;
    end
  end

  // Pipeline occupancy: a stage loads when empty or when it drains this cycle
  logic v1, v2, v3;
  logic ld1, ld2, ld3, accept;

  assign ld3    = ~v3 | bus.i_ready;
  assign ld2    = ~v2 | ld3;
  assign ld1    = ~v1 | ld2;
  assign bus.o_ready = ld1 & ~i_flush;
  assign accept = bus.i_valid & bus.o_ready;

  logic                      s1, s2;
  logic signed [SIZE_SE-1:0] e1, e2;
  logic [SIZE_M1-1:0]        ma1, mb1;
  logic [SIZE_P-1:0]         p2;
  kind_t                     k1, k2;
  logic                      inv1, inv2;
  logic [SIZE_TAG-1:0]       t1, t2, t3;
  logic [SIZE_DATA-1:0]      r3;
  logic [3:0]                f3;

  // Normalise and round stage-2 product
  logic                      msb, guard, sticky, up;
  logic [SIZE_P-1:0]         sh;
  logic [SIZE_MAN-1:0]       frac;
  logic [SIZE_MAN:0]         frac_r;
  logic signed [SIZE_SE-1:0] ef;
  logic [SIZE_DATA-1:0]      res;
  logic [3:0]                flg;

  assign msb    = p2[SIZE_P-1];
  assign sh     = msb ? p2 : (p2 << 1);
  assign frac   = sh[SIZE_P-2 -: SIZE_MAN];
  assign guard  = sh[SIZE_P-2-SIZE_MAN];
  assign sticky = |sh[SIZE_P-3-SIZE_MAN:0];
  assign up     = guard & (sticky | frac[0]);
  assign frac_r = {1'b0, frac} + {{SIZE_MAN{1'b0}}, up};
  assign ef     = e2 + $signed(SIZE_SE'(msb)) + $signed(SIZE_SE'(frac_r[SIZE_MAN]));

  always_comb begin
    res = '0;
    flg = 4'b0000;
    case (k2)
      K_QNAN: begin
        res = {1'b0, EXP_ONES, 1'b1, {(SIZE_MAN-1){1'b0}}};
        flg = {inv2, 3'b000};
      end
      K_INF:  res = {s2, EXP_ONES, {SIZE_MAN{1'b0}}};
      K_ZERO: res = {s2, {(SIZE_DATA-1){1'b0}}};
      default: begin
        if (ef >= SE_ONES) begin
          res = {s2, EXP_ONES, {SIZE_MAN{1'b0}}};
          flg = 4'b0101;
        end else if (ef <= SE_ZERO) begin
          res = {s2, {(SIZE_DATA-1){1'b0}}};
          flg = 4'b0011;
        end else begin
          res = {s2, ef[SIZE_EXP-1:0], frac_r[SIZE_MAN-1:0]};
          flg = {3'b000, guard | sticky};
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      s1 <= 1'b0; e1 <= '0; ma1 <= '0; mb1 <= '0; k1 <= K_NORM; inv1 <= 1'b0; t1 <= '0;
      s2 <= 1'b0; e2 <= '0; p2 <= '0; k2 <= K_NORM; inv2 <= 1'b0; t2 <= '0;
      r3 <= '0; f3 <= '0; t3 <= '0;
    end else begin
      if (i_flush) begin
        v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      end else begin
        if (ld1) v1 <= accept;
        if (ld2) v2 <= v1;
        if (ld3) v3 <= v2;
      end
      if (ld1) begin
        s1   <= sa ^ sb;
        e1   <= exp_in;
        ma1  <= {1'b1, fa};
        mb1  <= {1'b1, fb};
        k1   <= kind_in;
        inv1 <= inv_in;
        t1   <= bus.i_tag;
      end
      if (ld2) begin
        s2   <= s1;
        e2   <= e1;
        p2   <= SIZE_P'(ma1) * SIZE_P'(mb1);
        k2   <= k1;
        inv2 <= inv1;
        t2   <= t1;
      end
      // Output registers only change when a real result replaces them
      if (ld3 && v2) begin
        r3 <= res;
        f3 <= flg;
        t3 <= t2;
      end
    end
  end

  assign bus.o_valid  = v3;
  assign bus.o_32_mul = r3;
  assign bus.o_flags  = f3;
  assign bus.o_tag    = t3;
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// tb/tb_fpu_mul_pipe.sv - directed and streaming checks for fpu_mul_pipe
module tb_fpu_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  fpu_mul_pipe_if #(.SIZE_EXP(8), .SIZE_MAN(23), .SIZE_TAG(4)) bus ();

  fpu_mul_pipe #(.SIZE_EXP(8), .SIZE_MAN(23), .SIZE_TAG(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Independent golden: exact product in double precision, then RNE to single with FTZ
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    int e;
    e = int'(x[30:23]) - 127 + 1023;
    d = {x[31], 11'(e), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [35:0] golden(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          e;
    logic [22:0] keep;
    logic [28:0] rem;
    logic        up;
    logic [23:0] kr;
    r    = f2r(a) * f2r(b);
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 1023 + 127;
    keep = d[51:29];
    rem  = d[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    kr   = {1'b0, keep} + 24'(up);
    if (kr[23]) e++;
    if (e >= 255) return {4'b0101, d[63], 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, d[63], 31'd0};
    return {3'b000, rem != 0, d[63], e[7:0], kr[22:0]};
  endfunction

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg, input string name);
    int lat;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_32_a  = a;
    bus.i_32_b  = b;
    bus.i_tag   = tag;
    bus.i_ready = 1'b1;
    #1 check({name, "_ready"}, 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      #1 lat++;
    end while (!bus.o_valid && lat < 8);
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_result"}, 64'(bus.o_32_mul), 64'(exp_res));
    check({name, "_flags"}, 64'(bus.o_flags), 64'(exp_flg));
    check({name, "_tag"}, 64'(bus.o_tag), 64'(tag));
  endtask

  logic [31:0] rom_a [2048];
  logic [31:0] rom_b [2048];
  logic [39:0] q [$];

  initial begin
    int          acc, idx, recv, cycles;
    logic        seen, prev_stall;
    logic [40:0] prev_out, cur_out;
    logic [39:0] exp_beat;
    logic [35:0] g;

    bus.i_valid = 1'b0;
    bus.i_32_a  = '0;
    bus.i_32_b  = '0;
    bus.i_tag   = '0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      rom_a[i] = {1'($urandom), 8'($urandom_range(50, 200)), 23'($urandom)};
      rom_b[i] = {1'($urandom), 8'($urandom_range(50, 200)), 23'($urandom)};
    end

    repeat (3) @(negedge clk);
    #1;
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_mul", 64'(bus.o_32_mul), 64'd0);
    check("reset_flags", 64'(bus.o_flags), 64'd0);
    check("reset_tag", 64'(bus.o_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_ready", 64'(bus.o_ready), 64'd1);

    run_one(32'h40400000, 32'h40000000, 4'h1, 32'h40C00000, 4'b0000, "basic_3x2");
    run_one(32'h3F800000, 32'h403F5C29, 4'h2, 32'h403F5C29, 4'b0000, "basic_1xk");
    run_one(32'h3F800001, 32'h3F800001, 4'h3, 32'h3F800002, 4'b0001, "round_down");
    run_one(32'h3F800003, 32'h3FC00000, 4'h4, 32'h3FC00004, 4'b0001, "round_tie_even");
    run_one(32'h7F800000, 32'h00000000, 4'h5, 32'h7FC00000, 4'b1000, "inf_x_zero");
    run_one(32'hFF800000, 32'h40533333, 4'h6, 32'hFF800000, 4'b0000, "neg_inf_x_norm");
    run_one(32'h7F800001, 32'hC00CCCCD, 4'h7, 32'h7FC00000, 4'b1000, "snan");
    run_one(32'h7FC00000, 32'h3F800000, 4'h8, 32'h7FC00000, 4'b0000, "qnan");
    run_one(32'h80000000, 32'h40000000, 4'h9, 32'h80000000, 4'b0000, "neg_zero");
    run_one(32'h7F7FFFFF, 32'h40000000, 4'hA, 32'h7F800000, 4'b0101, "overflow");
    run_one(32'h0CFFFFFF, 32'h00F80000, 4'hB, 32'h00000000, 4'b0011, "underflow");
    run_one(32'h007FFFFF, 32'h3F800000, 4'hC, 32'h00000000, 4'b0000, "subnormal_ftz");
    run_one(32'h3FFFFFFF, 32'h3FFFFFFF, 4'hD, 32'h407FFFFE, 4'b0001, "carry_norm");

    // Backpressure: only three beats fit with the sink stalled
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_32_a  = 32'h40400000;
      bus.i_32_b  = 32'h40000000;
      bus.i_tag   = 4'(i);
      #1 if (bus.o_ready) acc++;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_ready_low", 64'(bus.o_ready), 64'd0);
    check("bp_valid", 64'(bus.o_valid), 64'd1);
    prev_out = {bus.o_valid, bus.o_tag, bus.o_flags, bus.o_32_mul};
    @(negedge clk);
    #1 check("bp_hold", 64'({bus.o_valid, bus.o_tag, bus.o_flags, bus.o_32_mul}), 64'(prev_out));
    check("bp_hold_value", 64'(bus.o_32_mul), 64'h40C00000);

    // Flush with three beats in flight, plus a beat offered during the flush cycle
    @(negedge clk);
    flush = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_tag   = 4'hF;
    #1 check("flush_ready", 64'(bus.o_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    #1 check("flush_valid", 64'(bus.o_valid), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 seen = seen | bus.o_valid;
    end
    check("flush_no_ghost", 64'(seen), 64'd0);

    // Stream with random sink backpressure against the golden model
    idx = 0; recv = 0; cycles = 0; prev_stall = 1'b0; prev_out = '0;
    while (recv < 2048 && cycles < 30000) begin
      @(negedge clk);
      bus.i_ready = ($urandom_range(0, 2) != 0);
      bus.i_valid = (idx < 2048) && ($urandom_range(0, 3) != 0);
      bus.i_32_a  = rom_a[idx % 2048];
      bus.i_32_b  = rom_b[idx % 2048];
      bus.i_tag   = 4'(idx % 16);
      #1;
      cur_out = {bus.o_valid, bus.o_tag, bus.o_flags, bus.o_32_mul};
      if (prev_stall) check("stream_hold", 64'(cur_out), 64'(prev_out));
      prev_stall = bus.o_valid & ~bus.i_ready;
      prev_out   = cur_out;
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          check("stream_extra_beat", 64'd1, 64'd0);
        end else begin
          exp_beat = q.pop_front();
          check("stream_beat", 64'({bus.o_tag, bus.o_flags, bus.o_32_mul}), 64'(exp_beat));
        end
        recv++;
      end
      if (bus.i_valid && bus.o_ready) begin
        g = golden(rom_a[idx], rom_b[idx]);
        q.push_back({4'(idx % 16), g});
        idx++;
      end
      cycles++;
    end
    check("stream_sent", 64'(idx), 64'd2048);
    check("stream_received", 64'(recv), 64'd2048);
    check("stream_queue_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      bus.i_32_a  = 32'h3F800001;
      bus.i_32_b  = 32'h3F800001;
      bus.i_tag   = 4'h5;
    end
    #1;
    check("pre_reset_valid", 64'(bus.o_valid), 64'd1);
    check("pre_reset_flags", 64'(bus.o_flags), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 64'(bus.o_valid), 64'd0);
    check("mid_reset_mul", 64'(bus.o_32_mul), 64'd0);
    check("mid_reset_flags", 64'(bus.o_flags), 64'd0);
    check("mid_reset_tag", 64'(bus.o_tag), 64'd0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    #1 check("post_reset_ready", 64'(bus.o_ready), 64'd1);
    run_one(32'h40400000, 32'h40000000, 4'h3, 32'h40C00000, 4'b0000, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpu_mul_pipe.md
# fpu_mul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes on input and output, a sideband tag, and exception flags. It replaces the single-cycle 32-bit multiplier on the FFT butterfly datapath so that the multiply no longer limits clock frequency. It also supports backpressure from the downstream adder stage. Three register stages, one result per cycle when unstalled.

## Interface
- SIZE_EXP, 8, exponent width
- SIZE_MAN, 23, stored fraction width
- SIZE_DATA, 1+SIZE_EXP+SIZE_MAN, operand/result width (derived, do not override)
- SIZE_TAG, 4, sideband tag width (FFT sample index)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous pipeline clear
- i_valid  in  1  operand beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_32_a, i_32_b  in  SIZE_DATA  operands
- i_tag  in  SIZE_TAG  carried unchanged to o_tag
- o_valid  out  1  result beat valid
- i_ready  in  1  downstream accepts result
- o_32_mul  out  SIZE_DATA  product
- o_tag  out  SIZE_TAG  tag of this result
- o_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Stage 1 (unpack): sign = sa^sb; classify each operand as zero (exp==0, subnormals flushed to zero), inf, NaN, or normal; exp sum = ea+eb-bias, held in SIZE_EXP+2 bits signed; register special-case code.
- Stage 2 (multiply): (1.fa)×(1.fb) gives a full 2*(SIZE_MAN+1)-bit product. Register the product.
- Stage 3 (normalise/round):
  - If product bit MSB is set, shift right 1 and increment exp.
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry-out renormalises and increments exp again.
  - If exp ≥ all-ones: result is ±inf, overflow=1, inexact=1.
  - If exp ≤ 0: result is ±0, underflow=1, inexact=1 (flush-to-zero, no subnormal output).
- Specials override arithmetic:
  - Any NaN input gives canonical qNaN (0, all-ones exp, fraction MSB only; 7FC00000 at defaults). invalid=1 only for signalling NaN input.
  - inf×0 gives qNaN with invalid=1.
  - inf×normal and inf×inf give sign-correct inf, no flags.
  - zero×normal gives sign-correct zero, no flags.
- Flags are per-result, not sticky. Flags are valid only with o_valid.

## Timing
- Each stage holds a valid bit. A stage loads when it is empty or when its contents move forward this cycle.
  - stage3 moves when o_valid & i_ready.
  - Bubbles collapse.
- o_ready = ~v1 | stage1 moving (combinational from i_ready, no registered skid).
- A beat accepted in cycle N (i_valid & o_ready at edge N) is presented with o_valid=1 in cycle N+3 when unstalled. Throughput is 1 beat/cycle.
- With i_ready held 0, at most 3 beats are accepted, then o_ready=0.
- o_32_mul, o_tag, o_flags hold stable while o_valid & ~i_ready.
- i_flush: all valid bits clear at the next edge. A beat offered in the same cycle is dropped, and o_ready is forced 0 that cycle.
- Reset (asynchronous, any time including mid-stream):
  - All valid bits are 0, so o_valid=0.
  - o_32_mul=0, o_tag=0, o_flags=0.
  - o_ready=1 from the first cycle after release. In-flight beats are discarded.

## Test plan
- Basic products, i_ready=1:
  - 40400000×40000000 → 40C00000, flags 0000, o_valid 3 cycles after accept.
  - 3F800000×403F5C29 → 403F5C29.
- Rounding:
  - 3F800001×3F800001 → 3F800002, inexact=1.
  - Tie case 3F800003×3FC00000 → 3FC00004 (even), inexact=1.
- Specials:
  - 7F800000×00000000 → 7FC00000, invalid=1.
  - FF800000×40533333 → FF800000, flags 0.
  - 7F800001×C00CCCCD → 7FC00000, invalid=1.
  - 80000000×40000000 → 80000000.
- Range:
  - 7F7FFFFF×40000000 → 7F800000, overflow+inexact.
  - 0CFFFFFF×00F80000 → 00000000, underflow+inexact.
  - Subnormal 007FFFFF×3F800000 → 00000000.
- Backpressure:
  - Stream 2048 ROM operand pairs with tags = index mod 16 while toggling i_ready pseudo-randomly.
  - Every result matches the golden model in order with correct tag.
  - No beat lost or duplicated.
  - With i_ready=0, exactly 3 beats are accepted before o_ready falls.
- Flush/reset:
  - Assert i_flush with 3 beats in flight → o_valid=0 next cycle, those results never appear.
  - Assert i_rst_n=0 mid-stream → o_valid, o_32_mul, o_flags go to 0 immediately.
  - After release, a new beat returns a correct result after 3 cycles.
